// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier: kind encodings,
// FSM state type and the iteration count.
package mul_pkg;

  localparam int MUL_ITERS = 32;

  localparam logic [1:0] MUL_K   = 2'b00;
  localparam logic [1:0] UMULL_K = 2'b10;
  localparam logic [1:0] SMULL_K = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional two's complement negation. Used for operand magnitudes on
// entry and for restoring the product sign at completion.
module mul_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  // Magnitude is held unsigned, so negating the most negative value is benign
  always_comb begin
    dout = din;
    if (neg) dout = ~din + W'(1);
  end

endmodule

// File: rtl/mul_seq_unit.sv
// Iterative WIDTHxWIDTH shift-add multiplier, one multiplier bit per cycle.
// Optional macro MUL_SIGNED_EN compiles in SMULL support (operand magnitude,
// sign latch, final negation); without it kind 11 behaves as UMULL.
module mul_seq_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       kind,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_e                   state;
  logic [CW-1:0]            cnt;
  logic [PW-1:0]            acc;
  logic [PW-1:0]            mcand;
  logic [WIDTH-1:0]         mplier;
  logic                     long_q;

  logic [1:0][WIDTH-1:0]    ops;
  logic [1:0][WIDTH-1:0]    mags;
  logic [PW-1:0]            acc_nxt;
  logic [PW-1:0]            prod;

  assign ops     = {src_b, src_a};
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef MUL_SIGNED_EN
  logic       sign_q;
  logic [1:0] neg_v;

  // Lane 0 is the multiplicand, lane 1 the multiplier
  for (genvar g = 0; g < 2; g++) begin : g_op_fix
    assign neg_v[g] = (kind == SMULL_K) & ops[g][WIDTH-1];
    mul_sign_fix #(.W(WIDTH)) u_op_fix (
      .neg  (neg_v[g]),
      .din  (ops[g]),
      .dout (mags[g])
    );
  end

  mul_sign_fix #(.W(PW)) u_prod_fix (
    .neg  (sign_q),
    .din  (acc_nxt),
    .dout (prod)
  );
`else
  logic unused_kind0;
  assign unused_kind0 = kind[0];
  assign mags         = ops;
  assign prod         = acc_nxt;
`endif

  // Control FSM, one shift-add step per RUN cycle, results captured on DONE entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      long_q    <= 1'b0;
`ifdef MUL_SIGNED_EN
      sign_q    <= 1'b0;
`endif
      result_lo <= '0;
      result_hi <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            cnt    <= CW'(WIDTH - 1);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mags[0]};
            mplier <= mags[1];
            long_q <= kind[1];
`ifdef MUL_SIGNED_EN
            sign_q <= neg_v[0] ^ neg_v[1];
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result_lo <= prod[WIDTH-1:0];
            result_hi <= long_q ? prod[PW-1:WIDTH] : '0;
            flag_n    <= long_q ? prod[PW-1] : prod[WIDTH-1];
            flag_z    <= long_q ? (prod == '0) : (prod[WIDTH-1:0] == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_seq_unit.md
# mul_seq_unit

Iterative 32×32 shift-add multiplier serving the multicycle controller's multiply state. The main FSM enters its multiply state on `is_mul`, pulses `start` with the register-file operands, holds while `busy` is high, and moves to ALU write-back on `done`. Results are held in output registers for the write-back (and long-multiply high-word) cycles.

## Interface
Parameters:
- `WIDTH`, 32, operand width. The product width is 2×WIDTH.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request. Sampled only in IDLE or DONE.
- `kind`  in  2  operation select: 00 MUL, 10 UMULL, 11 SMULL. 01 is treated as MUL.
- `src_a`  in  WIDTH  multiplicand (Rm).
- `src_b`  in  WIDTH  multiplier (Rs).
- `busy`  out  1  iteration in progress.
- `done`  out  1  single-cycle pulse; results valid.
- `result_lo`  out  WIDTH  product bits [WIDTH-1:0].
- `result_hi`  out  WIDTH  product bits [2·WIDTH-1:WIDTH]. Forced to 0 for MUL.
- `flag_n`  out  1  N flag for the S-bit update: bit 31 for MUL, bit 63 for long forms.
- `flag_z`  out  1  Z flag: all result bits of the selected width are zero.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE after WIDTH iterations.
  - DONE → RUN if `start`, else DONE → IDLE.
- On start acceptance:
  - Latch `kind`, and `src_a`/`src_b` into the multiplicand and multiplier registers.
  - Clear the 2·WIDTH accumulator.
  - Load the 5-bit iteration counter with WIDTH-1.
  - For SMULL, latch the magnitudes of both operands plus `sign = a[31]^b[31]`.
- RUN, each cycle:
  - If multiplier[0] is set, accumulator += multiplicand << i.
  - Shift the multiplier right by one.
  - Decrement the counter.
  - Leave RUN when the counter equals 0 in the same cycle it is processed.
- Entering DONE:
  - Product = sign ? −acc (64-bit two's complement) : acc.
  - Register `result_lo`, `result_hi`, `flag_n` and `flag_z`.
- Arithmetic:
  - Magnitude of 0x80000000 is 0x80000000; no overflow, since the magnitude is held unsigned.
  - All accumulation is 64-bit, and carries out of bit 63 are discarded.
- Rules:
  - `start` during RUN is ignored; no queueing.
  - Result registers hold their value until the next DONE entry.
  - Changes on `src_a`/`src_b` after acceptance have no effect.
- Reset (low at any edge, including mid-RUN):
  - State returns to IDLE.
  - `busy`=0, `done`=0.
  - `result_lo`, `result_hi`, `flag_n`, `flag_z` = 0.
  - Counter and accumulator = 0.
  - An in-flight operation is abandoned with no `done`.

## Timing
- `start` high in cycle 0 (IDLE):
  - `busy` is high in cycles 1–32.
  - `done` is high in cycle 33 only.
  - Results are valid from cycle 33.
- Fixed latency of 33 cycles, independent of operand values. There is no early termination.
- Back-to-back: `start` in the DONE cycle (33) makes `busy` high again in cycle 34. Throughput is one product per 33 cycles.
- `busy` and `done` are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MUL_SIGNED_EN` defined:
  - SMULL is supported: sign latch, magnitude conversion and final negation are compiled in.
- `MUL_SIGNED_EN` undefined:
  - The sign logic is removed.
  - `kind` 11 behaves exactly as UMULL (operands treated as unsigned, no negation).
  - All other behaviour and latency are unchanged.

## Structure
- Shared package `mul_pkg` holds:
  - the `kind` encodings (MUL_K, UMULL_K, SMULL_K);
  - the state enum (IDLE, RUN, DONE);
  - `MUL_ITERS` = 32.
- One combinational sub-module, `mul_sign_fix`, is used twice:
  - operand magnitude conversion on entry;
  - conditional 64-bit product negation at DONE.
  - It is present only under `MUL_SIGNED_EN`.

## Test plan
- MUL, a=0x00000007, b=0x00000006 → `done` in cycle 33; result_lo=0x0000002A, result_hi=0, N=0, Z=0.
- UMULL, a=b=0xFFFFFFFF → result_hi=0xFFFFFFFE, result_lo=0x00000001, N=1.
- SMULL (with `MUL_SIGNED_EN`):
  - a=0xFFFFFFFF (−1), b=0x00000005 → hi=0xFFFFFFFF, lo=0xFFFFFFFB, N=1.
  - a=b=0x80000000 → hi=0x40000000, lo=0, N=0.
  - Without the macro, a=0xFFFFFFFF, b=5 gives hi=0x00000004, lo=0xFFFFFFFB.
- MUL, a=0x00010000, b=0x00010000 → lo=0, hi=0, Z=1. Then `start` asserted in the DONE cycle with a=3, b=3 → `busy` in cycle 34; `done` 33 cycles later with lo=9.
- `start` pulsed during RUN → ignored; exactly one `done`. Reset driven low in cycle 15 of RUN → next cycle IDLE with all outputs 0 and no `done` pulse.
